// File: rtl/yarvi_trace_buf.sv
// ----------------------------------------------------------------------------
// yarvi_trace_buf
//
// Retire-stream trace buffer. Captures one record per retiring instruction
// into a small FIFO and serialises each record as a sequence of 32-bit words
// on a valid/ready stream. The core is never stalled. When the FIFO is full,
// a retirement is dropped and counted instead, and the next accepted record
// carries that count.
//
// Optional feature macro: YARVI_TRACE_TS_EN
//   When defined, a free-running 32-bit cycle counter is sampled at push and
//   emitted as the final word of every record.
//
// Ports
//   clock        sole clock
//   reset_n      synchronous, active-low reset
//   trace_en     1 = capture retirements, 0 = ignore me_valid (no drop count)
//   me_valid     retire strobe
//   me_priv      privilege level of the retiring instruction
//   me_pc        pc of the retiring instruction (XLEN bits)
//   me_insn      retiring instruction
//   me_wb_rd     destination register (0 = none)
//   me_wb_val    writeback value (XLEN bits)
//   out_valid    out_data holds a valid word
//   out_ready    sink accepts the word
//   out_data     trace word
//   out_last     last word of the current record
//   trace_level  records currently buffered (including the one being emitted)
//   trace_ovf    sticky: at least one record dropped since reset
//
// Word order per record:
//   header {A5, seq, drop_cnt, priv, rd, rd!=0}, pc (low first), insn,
//   wb_val (low first), [timestamp]
// ----------------------------------------------------------------------------
module yarvi_trace_buf #(
   parameter int XLEN       = 64,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  trace_en,
   input  logic                  me_valid,
   input  logic [1:0]            me_priv,
   input  logic [XLEN-1:0]       me_pc,
   input  logic [31:0]           me_insn,
   input  logic [4:0]            me_wb_rd,
   input  logic [XLEN-1:0]       me_wb_val,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_data,
   output logic                  out_last,
   output logic [DEPTH_LOG2:0]   trace_level,
   output logic                  trace_ovf
);

   // Words per XLEN-wide field (1 for RV32, 2 for RV64).
   localparam int WPF = XLEN / 32;
`ifdef YARVI_TRACE_TS_EN
   localparam int NWORDS = 3 + 2 * WPF;
`else
   localparam int NWORDS = 2 + 2 * WPF;
`endif
   localparam int DEPTH = 1 << DEPTH_LOG2;

   localparam logic [2:0] LAST_IDX = 3'(NWORDS - 1);
   localparam logic [2:0] IDX_PC0  = 3'(1);
   localparam logic [2:0] IDX_PC1  = 3'(2);
   localparam logic [2:0] IDX_INSN = 3'(1 + WPF);
   localparam logic [2:0] IDX_WB0  = 3'(2 + WPF);
   localparam logic [2:0] IDX_WB1  = 3'(3 + WPF);
`ifdef YARVI_TRACE_TS_EN
   localparam logic [2:0] IDX_TS   = 3'(2 + 2 * WPF);
`endif

   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2:0]   LVL_ONE = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2:0]   LVL_ZERO = (DEPTH_LOG2 + 1)'(0);

   typedef struct packed {
      logic [7:0]      seq;
      logic [7:0]      drops;
      logic [1:0]      priv;
      logic [4:0]      rd;
      logic [XLEN-1:0] pc;
      logic [31:0]     insn;
      logic [XLEN-1:0] wb;
`ifdef YARVI_TRACE_TS_EN
      logic [31:0]     ts;
`endif
   } rec_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   // Select word idx of a record.
   function automatic logic [31:0] word_sel(input rec_t r, input logic [2:0] idx);
      logic [31:0] w;
      w = 32'h0000_0000;
      if (idx == 3'd0) begin
         w = {8'hA5, r.seq, r.drops, r.priv, r.rd, (r.rd != 5'd0)};
      end else if (idx == IDX_PC0) begin
         w = r.pc[31:0];
      end else if ((WPF == 2) && (idx == IDX_PC1)) begin
         w = r.pc[XLEN-1 -: 32];
      end else if (idx == IDX_INSN) begin
         w = r.insn;
      end else if (idx == IDX_WB0) begin
         w = r.wb[31:0];
      end else if ((WPF == 2) && (idx == IDX_WB1)) begin
         w = r.wb[XLEN-1 -: 32];
`ifdef YARVI_TRACE_TS_EN
      end else if (idx == IDX_TS) begin
         w = r.ts;
`endif
      end else begin
         w = 32'h0000_0000;
      end
      return w;
   endfunction

   rec_t                  mem_r [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_r;
   logic [DEPTH_LOG2-1:0] rd_ptr_r;
   logic [DEPTH_LOG2:0]   count_r;
   logic [DEPTH_LOG2:0]   count_nxt_s;
   logic [7:0]            seq_r;
   logic [7:0]            drop_cnt_r;
   logic                  ovf_r;
`ifdef YARVI_TRACE_TS_EN
   logic [31:0]           ts_cnt_r;
`endif

   state_t                state_r;
   state_t                state_nxt_s;
   logic [2:0]            k_r;
   logic [2:0]            k_nxt_s;
   logic                  out_valid_r;
   logic                  valid_nxt_s;
   logic [31:0]           out_data_r;
   logic [31:0]           data_nxt_s;
   logic                  out_last_r;
   logic                  last_nxt_s;

   logic                  push_req_s;
   logic                  full_s;
   logic                  accept_s;
   logic                  pop_s;
   logic                  push_ok_s;
   logic                  drop_s;
   logic                  more_s;
   rec_t                  rec_in_s;
   rec_t                  head_rec_s;
   rec_t                  nxt_rec_s;

   // Handshake decode and FIFO occupancy bookkeeping.
   always_comb begin
      push_req_s = trace_en & me_valid;
      full_s     = count_r[DEPTH_LOG2];
      accept_s   = out_valid_r & out_ready;
      pop_s      = accept_s & out_last_r;
      // A pop at the same edge frees the slot for a push into a full FIFO.
      push_ok_s  = push_req_s & (~full_s | pop_s);
      drop_s     = push_req_s & full_s & ~pop_s;
      case ({push_ok_s, pop_s})
         2'b10:   count_nxt_s = count_r + LVL_ONE;
         2'b01:   count_nxt_s = count_r - LVL_ONE;
         default: count_nxt_s = count_r;
      endcase
      more_s = (count_nxt_s != LVL_ZERO);
   end

   // Record assembled from the retire port plus current sequence/drop state.
   always_comb begin
      rec_in_s       = '0;
      rec_in_s.seq   = seq_r;
      rec_in_s.drops = drop_cnt_r;
      rec_in_s.priv  = me_priv;
      rec_in_s.rd    = me_wb_rd;
      rec_in_s.pc    = me_pc;
      rec_in_s.insn  = me_insn;
      rec_in_s.wb    = me_wb_val;
`ifdef YARVI_TRACE_TS_EN
      rec_in_s.ts    = ts_cnt_r;
`endif
   end

   // Current head and the record that becomes head after a pop; when only
   // one record is buffered the successor is the one being pushed this cycle.
   always_comb begin
      head_rec_s = mem_r[rd_ptr_r];
      if (count_r == LVL_ONE) begin
         nxt_rec_s = rec_in_s;
      end else begin
         nxt_rec_s = mem_r[rd_ptr_r + PTR_ONE];
      end
   end

   // FIFO storage write port.
   always_ff @(posedge clock) begin
      if (reset_n && push_ok_s) begin
         mem_r[wr_ptr_r] <= rec_in_s;
      end
   end

   // FIFO pointers, level, sequence number, drop counter and overflow flag.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         seq_r      <= 8'd0;
         drop_cnt_r <= 8'd0;
         ovf_r      <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         if (push_ok_s) begin
            wr_ptr_r   <= wr_ptr_r + PTR_ONE;
            seq_r      <= seq_r + 8'd1;
            drop_cnt_r <= 8'd0;
         end else if (drop_s) begin
            ovf_r <= 1'b1;
            if (drop_cnt_r != 8'hFF) begin
               drop_cnt_r <= drop_cnt_r + 8'd1;
            end
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

`ifdef YARVI_TRACE_TS_EN
   // Free-running cycle counter sampled into each record at push.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ts_cnt_r <= 32'd0;
      end else begin
         ts_cnt_r <= ts_cnt_r + 32'd1;
      end
   end
`endif

   // Serialiser next-state and next-output logic.
   always_comb begin
      state_nxt_s = state_r;
      k_nxt_s     = k_r;
      valid_nxt_s = out_valid_r;
      data_nxt_s  = out_data_r;
      last_nxt_s  = out_last_r;
      case (state_r)
         ST_IDLE: begin
            // Idle implies an empty FIFO, so the new record is taken directly
            // from the retire port to present W0 on the very next cycle.
            if (push_ok_s) begin
               state_nxt_s = ST_EMIT;
               k_nxt_s     = 3'd0;
               valid_nxt_s = 1'b1;
               data_nxt_s  = word_sel(rec_in_s, 3'd0);
               last_nxt_s  = (LAST_IDX == 3'd0);
            end else begin
               state_nxt_s = ST_IDLE;
               valid_nxt_s = 1'b0;
            end
         end
         ST_EMIT: begin
            if (accept_s) begin
               if (out_last_r) begin
                  if (more_s) begin
                     k_nxt_s     = 3'd0;
                     valid_nxt_s = 1'b1;
                     data_nxt_s  = word_sel(nxt_rec_s, 3'd0);
                     last_nxt_s  = 1'b0;
                  end else begin
                     state_nxt_s = ST_IDLE;
                     k_nxt_s     = 3'd0;
                     valid_nxt_s = 1'b0;
                     data_nxt_s  = 32'h0000_0000;
                     last_nxt_s  = 1'b0;
                  end
               end else begin
                  k_nxt_s    = k_r + 3'd1;
                  data_nxt_s = word_sel(head_rec_s, k_r + 3'd1);
                  last_nxt_s = ((k_r + 3'd1) == LAST_IDX);
               end
            end else begin
               // Hold the presented word until the sink takes it.
               valid_nxt_s = 1'b1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            k_nxt_s     = 3'd0;
            valid_nxt_s = 1'b0;
            data_nxt_s  = 32'h0000_0000;
            last_nxt_s  = 1'b0;
         end
      endcase
   end

   // Serialiser state and registered stream outputs.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         k_r         <= 3'd0;
         out_valid_r <= 1'b0;
         out_data_r  <= 32'h0000_0000;
         out_last_r  <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         k_r         <= k_nxt_s;
         out_valid_r <= valid_nxt_s;
         out_data_r  <= data_nxt_s;
         out_last_r  <= last_nxt_s;
      end
   end

   assign out_valid   = out_valid_r;
   assign out_data    = out_data_r;
   assign out_last    = out_last_r;
   assign trace_level = count_r;
   assign trace_ovf   = ovf_r;

endmodule
